// File: rtl/ps2_host_tx.sv
// ps2_host_tx: host-to-device PS/2 byte transmitter.
// Sends one command byte over the shared open-drain key_clk/key_data pins.
// The pins are driven only through active-high pull-low enables. rx_inhibit
// tells the companion receiver to ignore the bus while this block owns it.
//
// state      | meaning
// -----------+---------------------------------------------------------------
// IDLE       | bus released, tx_ready high, waiting for tx_valid
// INHIBIT    | key_clk pulled low for INHIBIT_CYCLES cycles
// START      | key_clk and key_data both low for one cycle (start bit)
// SEND       | key_clk released; drive data bits, parity and stop on device falls
// ACK        | sample the device acknowledge bit on the next fall
// WAIT_IDLE  | wait for both lines high, then report completion
module ps2_host_tx #(
    parameter int INHIBIT_CYCLES = 10_000,
    parameter int TIMEOUT_CYCLES = 2_000_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tx_valid,
    input  logic [7:0] tx_data,
    output logic       tx_ready,
    input  logic       key_clk_in,
    input  logic       key_data_in,
    output logic       key_clk_oe,
    output logic       key_data_oe,
    output logic       rx_inhibit,
    output logic       tx_done,
    output logic       tx_ack_ok,
    output logic       tx_err
);

    localparam int INH_W = (INHIBIT_CYCLES > 1) ? $clog2(INHIBIT_CYCLES + 1) : 1;
    localparam int TO_W  = 21;
    localparam logic [INH_W-1:0] INH_LAST = INH_W'(INHIBIT_CYCLES - 1);
    localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_INHIBIT   = 3'd1,
        ST_START     = 3'd2,
        ST_SEND      = 3'd3,
        ST_ACK       = 3'd4,
        ST_WAIT_IDLE = 3'd5
    } state_t;

    state_t           r_state;
    logic             r_clk_s1;
    logic             r_clk_s2;
    logic             r_clk_prev;
    logic             r_dat_s1;
    logic             r_dat_s2;
    logic [7:0]       r_shift;
    logic             r_parity;
    logic [3:0]       r_bit_cnt;
    logic [INH_W-1:0] r_inh_cnt;
    logic [TO_W-1:0]  r_to_cnt;
    logic             r_ack;
    logic             w_fall;

    // Synchronizers reset to 1 (idle bus level) so no false fall follows reset.
    assign w_fall = r_clk_prev & ~r_clk_s2;

    // Two-flop synchronizers for the pins plus the previous synced clock level.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_clk_s1   <= 1'b1;
            r_clk_s2   <= 1'b1;
            r_clk_prev <= 1'b1;
            r_dat_s1   <= 1'b1;
            r_dat_s2   <= 1'b1;
        end else begin
            r_clk_s1   <= key_clk_in;
            r_clk_s2   <= r_clk_s1;
            r_clk_prev <= r_clk_s2;
            r_dat_s1   <= key_data_in;
            r_dat_s2   <= r_dat_s1;
        end
    end

    // Transfer sequencer with registered pin enables and status outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= ST_IDLE;
            r_shift     <= 8'd0;
            r_parity    <= 1'b0;
            r_bit_cnt   <= 4'd0;
            r_inh_cnt   <= '0;
            r_to_cnt    <= '0;
            r_ack       <= 1'b0;
            key_clk_oe  <= 1'b0;
            key_data_oe <= 1'b0;
            tx_ready    <= 1'b1;
            rx_inhibit  <= 1'b0;
            tx_done     <= 1'b0;
            tx_ack_ok   <= 1'b0;
            tx_err      <= 1'b0;
        end else begin
            tx_done <= 1'b0;
            tx_err  <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (tx_valid && tx_ready) begin
                        r_shift    <= tx_data;
                        r_parity   <= ~^tx_data;
                        r_inh_cnt  <= '0;
                        key_clk_oe <= 1'b1;
                        key_data_oe <= 1'b0;
                        tx_ready   <= 1'b0;
                        rx_inhibit <= 1'b1;
                        r_state    <= ST_INHIBIT;
                    end
                end
                ST_INHIBIT: begin
                    // Device clock activity here is ignored: the host owns the clock.
                    if (r_inh_cnt == INH_LAST) begin
                        key_data_oe <= 1'b1;
                        r_state     <= ST_START;
                    end else begin
                        r_inh_cnt <= r_inh_cnt + 1'b1;
                    end
                end
                ST_START: begin
                    key_clk_oe <= 1'b0;
                    r_bit_cnt  <= 4'd0;
                    r_to_cnt   <= '0;
                    r_state    <= ST_SEND;
                end
                ST_SEND, ST_ACK, ST_WAIT_IDLE: begin
                    if (!w_fall && (r_to_cnt == TO_LAST)) begin
                        key_clk_oe  <= 1'b0;
                        key_data_oe <= 1'b0;
                        tx_err      <= 1'b1;
                        tx_ready    <= 1'b1;
                        rx_inhibit  <= 1'b0;
                        r_to_cnt    <= '0;
                        r_state     <= ST_IDLE;
                    end else begin
                        if (w_fall) begin
                            r_to_cnt <= '0;
                        end else begin
                            r_to_cnt <= r_to_cnt + 1'b1;
                        end
                        if (r_state == ST_SEND) begin
                            if (w_fall) begin
                                r_bit_cnt <= r_bit_cnt + 1'b1;
                                if (r_bit_cnt < 4'd8) begin
                                    key_data_oe <= ~r_shift[r_bit_cnt[2:0]];
                                end else if (r_bit_cnt == 4'd8) begin
                                    key_data_oe <= ~r_parity;
                                end else begin
                                    key_data_oe <= 1'b0;
                                    r_state     <= ST_ACK;
                                end
                            end
                        end else if (r_state == ST_ACK) begin
                            if (w_fall) begin
                                r_ack   <= ~r_dat_s2;
                                r_state <= ST_WAIT_IDLE;
                            end
                        end else begin
                            if (r_clk_s2 && r_dat_s2) begin
                                tx_done    <= 1'b1;
                                tx_ack_ok  <= r_ack;
                                tx_ready   <= 1'b1;
                                rx_inhibit <= 1'b0;
                                r_to_cnt   <= '0;
                                r_state    <= ST_IDLE;
                            end
                        end
                    end
                end
                default: begin
                    key_clk_oe  <= 1'b0;
                    key_data_oe <= 1'b0;
                    tx_ready    <= 1'b1;
                    rx_inhibit  <= 1'b0;
                    r_state     <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ps2_host_tx.sv
// tb_ps2_host_tx: scoreboard bench for ps2_host_tx with a PS/2 device model.
module tb_ps2_host_tx;

    localparam int INH = 20;
    localparam int TO  = 400;
    localparam int BUDGET = 5000;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       tx_valid = 1'b0;
    logic [7:0] tx_data = 8'd0;
    logic       tx_ready, key_clk_oe, key_data_oe, rx_inhibit, tx_done, tx_ack_ok, tx_err;
    logic       dev_clk = 1'b1;
    logic       dev_data = 1'b1;
    logic       key_clk_line, key_data_line;

    assign key_clk_line  = ~key_clk_oe & dev_clk;
    assign key_data_line = ~key_data_oe & dev_data;

    always #5 clk = ~clk;

    ps2_host_tx #(.INHIBIT_CYCLES(INH), .TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .rst(rst_n), .tx_valid(tx_valid), .tx_data(tx_data), .tx_ready(tx_ready),
        .key_clk_in(key_clk_line), .key_data_in(key_data_line),
        .key_clk_oe(key_clk_oe), .key_data_oe(key_data_oe), .rx_inhibit(rx_inhibit),
        .tx_done(tx_done), .tx_ack_ok(tx_ack_ok), .tx_err(tx_err)
    );

    typedef struct {
        logic       err;
        logic       ack;
        logic [9:0] frame;
    } exp_t;

    exp_t       exp_q[$];
    exp_t       mon_e;
    int         n_vec = 0;
    int         n_mis = 0;
    logic       dev_ack = 1'b1;
    logic       dev_silent = 1'b0;
    logic [9:0] dev_frame = 10'd0;
    int         dev_falls = 0;
    bit         dev_busy = 1'b0;
    int         dev_lo = 6;
    int         dev_hi = 6;
    bit         in_flight = 1'b0;
    int         viol = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Wire frame as the device should see it: data LSB first, odd parity, stop 1.
    function automatic logic [9:0] frame_of(input logic [7:0] d);
        logic p;
        p = (($countones(d) % 2) == 0);
        return {1'b1, p, d};
    endfunction

    // Device model: on a host request (clock released, data low) clock in 10 bits, then ACK.
    initial begin
        int g;
        forever begin
            @(negedge clk);
            if (rst_n && key_clk_line && !key_data_line && rx_inhibit) begin
                dev_busy  = 1'b1;
                dev_falls = 0;
                if (dev_silent) begin
                    g = 0;
                    while (rx_inhibit && g < BUDGET) begin
                        @(negedge clk);
                        g++;
                    end
                end else begin
                    repeat (dev_hi) @(negedge clk);
                    for (int k = 1; k <= 11; k++) begin
                        dev_clk   = 1'b0;
                        dev_falls = k;
                        repeat (dev_lo) @(negedge clk);
                        if (k <= 10) dev_frame[k-1] = key_data_line;
                        dev_clk = 1'b1;
                        repeat (dev_hi) @(negedge clk);
                        if (k == 10 && dev_ack) dev_data = 1'b0;
                        if (k == 11) dev_data = 1'b1;
                    end
                end
                dev_busy = 1'b0;
            end
        end
    end

    // Scoreboard monitor: pops one expectation per tx_done / tx_err pulse.
    always @(negedge clk) begin
        if (rst_n) begin
            if (tx_done || tx_err) begin
                chk("inhibit_held", viol, 0);
                viol = 0;
                if (exp_q.size() == 0) begin
                    chk("unexpected_end", exp_q.size(), 1);
                end else begin
                    mon_e = exp_q.pop_front();
                    chk("end_is_err", tx_err, mon_e.err);
                    chk("end_is_done", tx_done, !mon_e.err);
                    if (!mon_e.err) begin
                        chk("ack_ok", tx_ack_ok, mon_e.ack);
                        chk("wire_frame", dev_frame, mon_e.frame);
                    end
                end
            end else if (in_flight && !rx_inhibit) begin
                viol++;
            end
        end
    end

    // Inhibit timing monitor: clock pull-low length and start-bit lead on every transfer.
    int hi_cnt = 0;
    int rise_at = 0;
    logic prev_coe = 1'b0;
    logic prev_doe = 1'b0;
    always @(negedge clk) begin
        if (!rst_n) begin
            hi_cnt = 0;
            rise_at = 0;
            prev_coe = 1'b0;
            prev_doe = 1'b0;
        end else begin
            if (key_clk_oe) begin
                hi_cnt++;
                if (key_data_oe && !prev_doe) rise_at = hi_cnt;
            end else if (prev_coe) begin
                chk("inhibit_len", hi_cnt, INH + 1);
                chk("start_lead", rise_at, hi_cnt);
                hi_cnt = 0;
                rise_at = 0;
            end
            prev_coe = key_clk_oe;
            prev_doe = key_data_oe;
        end
    end

    task automatic send(input logic [7:0] d, input bit ack, input bit silent,
                        input bit hold, input logic [7:0] other, output int rel_to_end);
        int   g;
        bit   rel;
        logic pc;
        exp_t e;
        g = 0;
        while (!tx_ready && g < BUDGET) begin
            @(negedge clk);
            g++;
        end
        dev_ack    = ack;
        dev_silent = silent;
        dev_lo     = $urandom_range(5, 9);
        dev_hi     = $urandom_range(4, 9);
        e.err   = silent;
        e.ack   = ack;
        e.frame = frame_of(d);
        exp_q.push_back(e);
        tx_valid = 1'b1;
        tx_data  = d;
        @(negedge clk);
        in_flight = 1'b1;
        if (hold) tx_data = other;
        else tx_valid = 1'b0;
        rel = 1'b0;
        rel_to_end = 0;
        pc = key_clk_oe;
        g = 0;
        while (g < BUDGET) begin
            @(negedge clk);
            g++;
            if (pc && !key_clk_oe) begin
                rel = 1'b1;
                rel_to_end = 0;
            end else if (rel) begin
                rel_to_end++;
            end
            pc = key_clk_oe;
            if (tx_done || tx_err) break;
        end
        tx_valid  = 1'b0;
        in_flight = 1'b0;
        chk("transfer_ended", tx_done | tx_err, 1);
        @(negedge clk);
    endtask

    initial begin
        int r;
        int g;
        repeat (3) @(negedge clk);
        chk("rst_clk_oe", key_clk_oe, 0);
        chk("rst_data_oe", key_data_oe, 0);
        chk("rst_tx_ready", tx_ready, 1);
        chk("rst_rx_inhibit", rx_inhibit, 0);
        chk("rst_tx_done", tx_done, 0);
        chk("rst_tx_err", tx_err, 0);
        chk("rst_tx_ack_ok", tx_ack_ok, 0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        send(8'hED, 1'b1, 1'b0, 1'b0, 8'h00, r);
        send(8'h00, 1'b0, 1'b0, 1'b0, 8'h00, r);
        chk("ack_holds", tx_ack_ok, 0);

        send(8'h5A, 1'b0, 1'b1, 1'b0, 8'h00, r);
        chk("timeout_len", r, TO);
        chk("timeout_clk_oe", key_clk_oe, 0);
        chk("timeout_data_oe", key_data_oe, 0);
        chk("timeout_ready", tx_ready, 1);

        // Reset in the middle of the data bits.
        g = 0;
        while (dev_busy && g < BUDGET) begin @(negedge clk); g++; end
        dev_ack = 1'b1;
        dev_silent = 1'b0;
        dev_lo = 6;
        dev_hi = 6;
        tx_valid = 1'b1;
        tx_data = 8'hA5;
        @(negedge clk);
        tx_valid = 1'b0;
        in_flight = 1'b1;
        g = 0;
        while (!(dev_busy && dev_falls == 5) && g < BUDGET) begin @(negedge clk); g++; end
        chk("reached_bit4", dev_falls, 5);
        repeat (4) @(negedge clk);
        rst_n = 1'b0;
        in_flight = 1'b0;
        #1;
        chk("midrst_clk_oe", key_clk_oe, 0);
        chk("midrst_data_oe", key_data_oe, 0);
        chk("midrst_ready", tx_ready, 1);
        g = 0;
        while (dev_busy && g < BUDGET) begin @(negedge clk); g++; end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        send(8'hFF, 1'b1, 1'b0, 1'b0, 8'h00, r);

        // tx_valid held with a different byte for the whole transfer.
        send(8'h3C, 1'b1, 1'b0, 1'b1, 8'hC3, r);
        repeat (30) @(negedge clk);
        chk("no_second_clk_oe", key_clk_oe, 0);
        chk("no_second_ready", tx_ready, 1);

        for (int i = 0; i < 6; i++) begin
            send(8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)), 1'b0, 1'b0, 8'h00, r);
        end

        repeat (10) @(negedge clk);
        chk("queue_drained", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end

endmodule
